imu_sensor_axi_slave: RTL and testbench

AXI4-Lite responder for the IMU sensor emulator: it implements the slave end of the S00_AXI register interface that the processor or bus-functional master writes and reads. It holds four 32-bit read/write registers at byte offsets 0x00, 0x04, 0x08 and 0x0C. It accepts the write-address and write-data channels independently and in either order, and returns write and read responses under full VALID/READY flow control. Register contents drive the sensor emulation core through dedicated outputs.

---
 rtl/imu_sensor_axi_slave_if.sv | 56 +++++
 rtl/imu_sensor_axi_slave.sv | 167 ++++++++++++++++
 tb/tb_imu_sensor_axi_slave.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imu_sensor_axi_slave_if.sv
// ---------------------------------------------------------------------------
// imu_sensor_axi_slave_if
//   AXI4-Lite bundle for the S00_AXI register port of the IMU sensor emulator.
//   Clock and reset are carried as plain ports on the modules, not in here.
//
//   Parameters:
//     ADDR_WIDTH - byte address width (6 -> 64-byte window)
//     DATA_WIDTH - data bus width (32 only)
//
//   Signals:
//     awaddr/awprot/awvalid/awready - write address channel
//     wdata/wstrb/wvalid/wready     - write data channel
//     bresp/bvalid/bready           - write response channel
//     araddr/arprot/arvalid/arready - read address channel
//     rdata/rresp/rvalid/rready     - read data channel
//
//   Modports:
//     slave  - register block side (drives readies, responses, read data)
//     master - processor / bus-functional-model side
// ---------------------------------------------------------------------------
interface imu_sensor_axi_slave_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/imu_sensor_axi_slave.sv
// ---------------------------------------------------------------------------
// imu_sensor_axi_slave
//   AXI4-Lite responder holding four 32-bit read/write control registers
//   (byte offsets 0x00, 0x04, 0x08, 0x0C) for the IMU sensor emulation core.
//   Write address and write data are captured independently into holding
//   slots and committed one edge after both are present. Reads are answered
//   on the address handshake edge and never wait on the write path.
//
//   Ports:
//     s00_axi_aclk   - clock, rising edge
//     s00_axi_areset - synchronous active-high reset
//     s00_axi        - AXI4-Lite slave modport (imu_sensor_axi_slave_if)
//     reg0_out..3    - current register contents
//     reg_wr_pulse   - one-cycle pulse per register on each committed write
//
//   Build option:
//     IMU_AXI_SLVERR_EN - when defined, unmapped accesses answer SLVERR
//                         instead of OKAY.
// ---------------------------------------------------------------------------
module imu_sensor_axi_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                          s00_axi_aclk,
  input  logic                          s00_axi_areset,
  imu_sensor_axi_slave_if.slave         s00_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg0_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg1_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg2_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg3_out,
  output logic [3:0]                    reg_wr_pulse
);

  localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef IMU_AXI_SLVERR_EN
  localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
  localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];

  logic                          ready_en;
  logic                          aw_full;
  logic                          w_full;
  logic [IDX_W-1:0]              aw_index;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]             w_strb;
  logic                          bvalid;
  logic [1:0]                    bresp;
  logic                          rvalid;
  logic [1:0]                    rresp;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata;

  logic             aw_hs;
  logic             w_hs;
  logic             ar_hs;
  logic             commit;
  logic             aw_mapped;
  logic             ar_mapped;
  logic [IDX_W-1:0] ar_index;
  logic             unused_bits;

  // ready_en keeps every ready low during reset and for the reset edge
  // itself; the channels open on the first edge after reset is released.
  assign s00_axi.awready = ready_en && !aw_full && !bvalid;
  assign s00_axi.wready  = ready_en && !w_full && !bvalid;
  assign s00_axi.arready = ready_en && !rvalid;
  assign s00_axi.bvalid  = bvalid;
  assign s00_axi.bresp   = bresp;
  assign s00_axi.rvalid  = rvalid;
  assign s00_axi.rresp   = rresp;
  assign s00_axi.rdata   = rdata;

  assign aw_hs     = s00_axi.awvalid && s00_axi.awready;
  assign w_hs      = s00_axi.wvalid && s00_axi.wready;
  assign ar_hs     = s00_axi.arvalid && s00_axi.arready;
  assign commit    = aw_full && w_full;
  assign ar_index  = s00_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign aw_mapped = ((aw_index >> 2) == '0);
  assign ar_mapped = ((ar_index >> 2) == '0);

  assign reg0_out = regs[0];
  assign reg1_out = regs[1];
  assign reg2_out = regs[2];
  assign reg3_out = regs[3];

  // Protection bits and the sub-word address bits carry no meaning here.
  assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot,
                         s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

  // Write path. The slots cannot load while both are full (their readies
  // are low), and bvalid is always clear while both are full, so the commit
  // branch never has to merge with a new handshake or a B handshake.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      ready_en     <= 1'b0;
      aw_full      <= 1'b0;
      w_full       <= 1'b0;
      aw_index     <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      bvalid       <= 1'b0;
      bresp        <= RESP_OKAY;
      reg_wr_pulse <= '0;
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
    end else begin
      ready_en     <= 1'b1;
      reg_wr_pulse <= '0;
      if (commit) begin
        if (aw_mapped) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (w_strb[b]) begin
              regs[aw_index[1:0]][8*b +: 8] <= w_data[8*b +: 8];
            end
          end
          reg_wr_pulse <= 4'b0001 << aw_index[1:0];
          bresp        <= RESP_OKAY;
        end else begin
          bresp <= RESP_UNMAPPED;
        end
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bvalid  <= 1'b1;
      end else begin
        if (aw_hs) begin
          aw_full  <= 1'b1;
          aw_index <= s00_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
          w_full <= 1'b1;
          w_data <= s00_axi.wdata;
          w_strb <= s00_axi.wstrb;
        end
        if (bvalid && s00_axi.bready) begin
          bvalid <= 1'b0;
        end
      end
    end
  end

  // Read path. rdata samples regs before any same-edge commit lands, so a
  // colliding read returns the pre-write value.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      rvalid <= 1'b0;
      rresp  <= RESP_OKAY;
      rdata  <= '0;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      if (ar_mapped) begin
        rdata <= regs[ar_index[1:0]];
        rresp <= RESP_OKAY;
      end else begin
        rdata <= '0;
        rresp <= RESP_UNMAPPED;
      end
    end else if (rvalid && s00_axi.rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imu_sensor_axi_slave.sv
// ---------------------------------------------------------------------------
// tb_imu_sensor_axi_slave
//   Directed bench for imu_sensor_axi_slave: reset state, sequential
//   write/readback, channel ordering, byte strobes, backpressure, unmapped
//   access and reset in the middle of a write. Inputs change 1 time unit
//   after the rising edge; outputs are sampled on the falling edge.
//   Honours IMU_AXI_SLVERR_EN for the expected unmapped response.
// ---------------------------------------------------------------------------
module tb_imu_sensor_axi_slave;

  logic        tb_ACLK = 1'b0;
  logic        tb_ARESET;
  logic [31:0] reg0_out;
  logic [31:0] reg1_out;
  logic [31:0] reg2_out;
  logic [31:0] reg3_out;
  logic [3:0]  reg_wr_pulse;

  int check_count = 0;
  int pass_count  = 0;
  int pulse_count [4] = '{0, 0, 0, 0};

`ifdef IMU_AXI_SLVERR_EN
  localparam logic [1:0] EXP_UNMAPPED_RESP = 2'b10;
`else
  localparam logic [1:0] EXP_UNMAPPED_RESP = 2'b00;
`endif

  imu_sensor_axi_slave_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) axi_if ();

  imu_sensor_axi_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6)
  ) dut (
    .s00_axi_aclk   (tb_ACLK),
    .s00_axi_areset (tb_ARESET),
    .s00_axi        (axi_if),
    .reg0_out       (reg0_out),
    .reg1_out       (reg1_out),
    .reg2_out       (reg2_out),
    .reg3_out       (reg3_out),
    .reg_wr_pulse   (reg_wr_pulse)
  );

  always #5 tb_ACLK = ~tb_ACLK;

  // Tally write pulses so each register can be shown to pulse exactly once.
  always @(negedge tb_ACLK) begin
    for (int b = 0; b < 4; b++) begin
      if (reg_wr_pulse[b]) pulse_count[b]++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, required finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
  endtask

  // Presents AW and/or W and drops each valid once its handshake edge passes.
  task automatic send_write(input logic [5:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input bit do_aw, input bit do_w);
    int cycles;
    bit aw_hs;
    bit w_hs;
    @(posedge tb_ACLK); #1;
    if (do_aw) begin
      axi_if.awaddr  = addr;
      axi_if.awvalid = 1'b1;
    end
    if (do_w) begin
      axi_if.wdata  = data;
      axi_if.wstrb  = strb;
      axi_if.wvalid = 1'b1;
    end
    cycles = 0;
    while ((axi_if.awvalid || axi_if.wvalid) && cycles < 50) begin
      @(negedge tb_ACLK);
      aw_hs = axi_if.awvalid && axi_if.awready;
      w_hs  = axi_if.wvalid && axi_if.wready;
      @(posedge tb_ACLK); #1;
      if (aw_hs) axi_if.awvalid = 1'b0;
      if (w_hs)  axi_if.wvalid  = 1'b0;
      cycles++;
    end
    if (axi_if.awvalid || axi_if.wvalid) begin
      check_output("write_handshake_timeout", 32'd0, 32'd1);
      axi_if.awvalid = 1'b0;
      axi_if.wvalid  = 1'b0;
    end
  endtask

  // Waits (bounded) for bvalid and captures the response and write pulse.
  task automatic wait_bresp(output logic [1:0] resp, output logic [3:0] pulse);
    int cycles = 0;
    @(negedge tb_ACLK);
    while (!axi_if.bvalid && cycles < 50) begin
      @(negedge tb_ACLK);
      cycles++;
    end
    if (!axi_if.bvalid) check_output("bvalid_timeout", 32'd0, 32'd1);
    resp  = axi_if.bresp;
    pulse = reg_wr_pulse;
  endtask

  task automatic apply_stimulus(input logic [5:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, output logic [1:0] resp,
                                output logic [3:0] pulse);
    send_write(addr, data, strb, 1'b1, 1'b1);
    wait_bresp(resp, pulse);
  endtask

  // Read: rvalid must be up right after the AR handshake edge.
  task automatic do_read(input logic [5:0] addr, output logic [31:0] data,
                         output logic [1:0] resp);
    int cycles;
    bit hs;
    @(posedge tb_ACLK); #1;
    axi_if.araddr  = addr;
    axi_if.arvalid = 1'b1;
    cycles = 0;
    hs = 1'b0;
    while (!hs && cycles < 50) begin
      @(negedge tb_ACLK);
      hs = axi_if.arvalid && axi_if.arready;
      @(posedge tb_ACLK); #1;
      if (hs) axi_if.arvalid = 1'b0;
      cycles++;
    end
    if (!hs) begin
      check_output("read_handshake_timeout", 32'd0, 32'd1);
      axi_if.arvalid = 1'b0;
    end
    check_output("read_rvalid", {31'd0, axi_if.rvalid}, 32'd1);
    data = axi_if.rdata;
    resp = axi_if.rresp;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [3:0]  pulse;
    logic [31:0] rd;
    int          stable;
    int          bv_seen;
    logic [31:0] seq_data [4] = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};

    tb_ARESET      = 1'b1;
    axi_if.awaddr  = '0;
    axi_if.awprot  = '0;
    axi_if.awvalid = 1'b0;
    axi_if.wdata   = '0;
    axi_if.wstrb   = '0;
    axi_if.wvalid  = 1'b0;
    axi_if.bready  = 1'b1;
    axi_if.araddr  = '0;
    axi_if.arprot  = '0;
    axi_if.arvalid = 1'b0;
    axi_if.rready  = 1'b1;

    // Reset state
    repeat (3) @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    check_output("rst_awready", {31'd0, axi_if.awready}, 32'd0);
    check_output("rst_wready",  {31'd0, axi_if.wready},  32'd0);
    check_output("rst_arready", {31'd0, axi_if.arready}, 32'd0);
    check_output("rst_valids",  {30'd0, axi_if.bvalid, axi_if.rvalid}, 32'd0);
    check_output("rst_regs",    reg0_out | reg1_out | reg2_out | reg3_out, 32'd0);
    check_output("rst_rdata",   axi_if.rdata, 32'd0);
    @(posedge tb_ACLK); #1;
    tb_ARESET = 1'b0;
    @(negedge tb_ACLK);
    @(negedge tb_ACLK);
    check_output("post_rst_awready", {31'd0, axi_if.awready}, 32'd1);

    // Sequential write/readback
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(6'(4 * i), seq_data[i], 4'hF, resp, pulse);
      check_output($sformatf("seq_bresp_%0d", i), {30'd0, resp}, 32'd0);
      check_output($sformatf("seq_pulse_%0d", i), {28'd0, pulse}, 32'(1 << i));
      do_read(6'(4 * i), rd, resp);
      check_output($sformatf("seq_rdata_%0d", i), rd, seq_data[i]);
      check_output($sformatf("seq_rresp_%0d", i), {30'd0, resp}, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("seq_pulse_count_%0d", i), pulse_count[i], 32'd1);
    end

    // Channel ordering: W three cycles ahead of AW
    @(posedge tb_ACLK); #1;
    axi_if.wdata  = 32'h12345678;
    axi_if.wstrb  = 4'hF;
    axi_if.wvalid = 1'b1;
    @(negedge tb_ACLK);
    check_output("order_wready_before", {31'd0, axi_if.wready}, 32'd1);
    @(posedge tb_ACLK); #1;
    axi_if.wvalid = 1'b0;
    @(negedge tb_ACLK);
    check_output("order_wready_drop", {31'd0, axi_if.wready}, 32'd0);
    repeat (2) @(posedge tb_ACLK);
    #1;
    axi_if.awaddr  = 6'h04;
    axi_if.awvalid = 1'b1;
    @(negedge tb_ACLK);
    check_output("order_awready", {31'd0, axi_if.awready}, 32'd1);
    @(posedge tb_ACLK); #1;
    axi_if.awvalid = 1'b0;
    @(negedge tb_ACLK);
    check_output("order_bvalid_early", {31'd0, axi_if.bvalid}, 32'd0);
    @(negedge tb_ACLK);
    check_output("order_bvalid", {31'd0, axi_if.bvalid}, 32'd1);
    check_output("order_pulse", {28'd0, reg_wr_pulse}, 32'h2);
    check_output("order_reg1", reg1_out, 32'h12345678);

    // Byte strobes on reg2 (0xDEAD0011)
    apply_stimulus(6'h08, 32'hFFFFFFFF, 4'b0101, resp, pulse);
    check_output("strb_reg2", reg2_out, 32'hDEFF00FF);
    do_read(6'h08, rd, resp);
    check_output("strb_rdata", rd, 32'hDEFF00FF);

    // Write response backpressure
    axi_if.bready = 1'b0;
    send_write(6'h0C, 32'h0BADF00D, 4'hF, 1'b1, 1'b1);
    wait_bresp(resp, pulse);
    check_output("bp_pulse", {28'd0, pulse}, 32'h8);
    stable = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge tb_ACLK);
      if (axi_if.bvalid && axi_if.bresp == 2'b00 && !axi_if.awready && !axi_if.wready)
        stable++;
    end
    check_output("bp_b_stable_cycles", stable, 32'd10);
    axi_if.bready = 1'b1;
    @(posedge tb_ACLK); #1;
    check_output("bp_bvalid_released", {31'd0, axi_if.bvalid}, 32'd0);
    check_output("bp_awready_back", {31'd0, axi_if.awready}, 32'd1);
    check_output("bp_reg3", reg3_out, 32'h0BADF00D);

    // Read data backpressure
    axi_if.rready = 1'b0;
    do_read(6'h0C, rd, resp);
    stable = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge tb_ACLK);
      if (axi_if.rvalid && axi_if.rdata == 32'h0BADF00D && axi_if.rresp == 2'b00 &&
          !axi_if.arready)
        stable++;
    end
    check_output("bp_r_stable_cycles", stable, 32'd10);
    axi_if.rready = 1'b1;
    @(posedge tb_ACLK); #1;
    check_output("bp_rvalid_released", {31'd0, axi_if.rvalid}, 32'd0);

    // Unmapped access at 0x20
    apply_stimulus(6'h20, 32'hCAFEBABE, 4'hF, resp, pulse);
    check_output("unmapped_bresp", {30'd0, resp}, {30'd0, EXP_UNMAPPED_RESP});
    check_output("unmapped_pulse", {28'd0, pulse}, 32'd0);
    check_output("unmapped_reg0", reg0_out, 32'h0101FFFF);
    check_output("unmapped_reg1", reg1_out, 32'h12345678);
    check_output("unmapped_reg2", reg2_out, 32'hDEFF00FF);
    check_output("unmapped_reg3", reg3_out, 32'h0BADF00D);
    do_read(6'h20, rd, resp);
    check_output("unmapped_rdata", rd, 32'd0);
    check_output("unmapped_rresp", {30'd0, resp}, {30'd0, EXP_UNMAPPED_RESP});

    // Reset between AW and W
    @(posedge tb_ACLK); #1;
    axi_if.awaddr  = 6'h08;
    axi_if.awvalid = 1'b1;
    @(negedge tb_ACLK);
    check_output("midrst_awready", {31'd0, axi_if.awready}, 32'd1);
    @(posedge tb_ACLK); #1;
    axi_if.awvalid = 1'b0;
    tb_ARESET      = 1'b1;
    @(posedge tb_ACLK); #1;
    tb_ARESET = 1'b0;
    @(negedge tb_ACLK);
    check_output("midrst_reg0", reg0_out, 32'd0);
    check_output("midrst_reg1", reg1_out, 32'd0);
    check_output("midrst_reg2", reg2_out, 32'd0);
    check_output("midrst_reg3", reg3_out, 32'd0);
    bv_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge tb_ACLK);
      if (axi_if.bvalid) bv_seen++;
    end
    check_output("midrst_no_bvalid", bv_seen, 32'd0);
    check_output("midrst_aw_slot_clear", {31'd0, axi_if.awready}, 32'd1);
    apply_stimulus(6'h08, 32'h600DCAFE, 4'hF, resp, pulse);
    check_output("midrst_bresp", {30'd0, resp}, 32'd0);
    check_output("midrst_pulse", {28'd0, pulse}, 32'h4);
    check_output("midrst_reg2_new", reg2_out, 32'h600DCAFE);
    do_read(6'h08, rd, resp);
    check_output("midrst_rdata", rd, 32'h600DCAFE);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
